// File: rtl/cv32e40p_x_wb_arbiter.sv
// Shares the register-file ALU write port between EX-stage writes and
// coprocessor (X) results. Results that cannot be written immediately wait in a small FIFO.
module cv32e40p_x_wb_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x_rvalid_i,
    input  logic [4:0]  x_rd_i,
    input  logic [31:0] x_data_i,
    output logic        x_rready_o,
    input  logic        ex_we_i,
    input  logic [5:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    output logic        wb_contention_o,
    output logic        rf_we_o,
    output logic [5:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic [3:0]  x_level_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [PTR_W-1:0] ptr_t;

    logic [4:0]  buf_rd_q   [DEPTH];
    logic [4:0]  buf_rd_d   [DEPTH];
    logic [31:0] buf_data_q [DEPTH];
    logic [31:0] buf_data_d [DEPTH];
    ptr_t        head_q, head_d, tail_q, tail_d;
    logic [3:0]  level_q, level_d;
    logic [3:0]  starve_q, starve_d;

    logic empty, full, x_fire, x_live, hazard, starved, pop, push, bypass;

    always_comb begin
        empty      = (level_q == 4'd0);
        full       = (level_q == 4'(DEPTH));
        x_rready_o = !rst && !full;
        x_fire     = x_rvalid_i && x_rready_o;
        x_live     = x_fire && (x_rd_i != 5'd0);

        // An EX write must not overtake an older buffered result to the same register.
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((4'(i) < level_q) && ({1'b0, buf_rd_q[head_q + ptr_t'(i)]} == ex_waddr_i))
                hazard = 1'b1;
        end
        hazard  = hazard && ex_we_i;
        starved = !empty && (starve_q == 4'(STARVE_LIMIT));

        pop    = !rst && !empty && (hazard || starved || !ex_we_i);
        bypass = !rst && empty && !ex_we_i && x_live;
        push   = x_live && !bypass;

        wb_contention_o = 1'b0;
        rf_we_o         = 1'b0;
        rf_waddr_o      = 6'd0;
        rf_wdata_o      = 32'd0;
        if (pop) begin
            rf_we_o         = 1'b1;
            rf_waddr_o      = {1'b0, buf_rd_q[head_q]};
            rf_wdata_o      = buf_data_q[head_q];
            wb_contention_o = ex_we_i;
        end else if (!rst && ex_we_i) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = ex_waddr_i;
            rf_wdata_o = ex_wdata_i;
        end else if (bypass) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = {1'b0, x_rd_i};
            rf_wdata_o = x_data_i;
        end
        x_level_o = rst ? 4'd0 : level_q;

        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        if (push) begin
            buf_rd_d[tail_q]   = x_rd_i;
            buf_data_d[tail_q] = x_data_i;
        end
        head_d  = pop  ? head_q + ptr_t'(1) : head_q;
        tail_d  = push ? tail_q + ptr_t'(1) : tail_q;
        level_d = level_q + {3'd0, push} - {3'd0, pop};

        if (pop || empty)
            starve_d = 4'd0;
        else if (starve_q != 4'(STARVE_LIMIT))
            starve_d = starve_q + 4'd1;
        else
            starve_d = starve_q;

        if (rst) begin
            head_d   = '0;
            tail_d   = '0;
            level_d  = 4'd0;
            starve_d = 4'd0;
        end
    end

    // NOTE: buffer storage is not reset; an entry is only read once level_q marks it valid.
    always_ff @(posedge clk) begin
        buf_rd_q   <= buf_rd_d;
        buf_data_q <= buf_data_d;
        head_q     <= head_d;
        tail_q     <= tail_d;
        level_q    <= level_d;
        starve_q   <= starve_d;
    end

endmodule

// File: tb/tb_cv32e40p_x_wb_arbiter.sv
// Directed and random stimulus against a queue-based model of the write-port arbitration rules.
module tb_cv32e40p_x_wb_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        x_rvalid_i;
    logic [4:0]  x_rd_i;
    logic [31:0] x_data_i;
    logic        x_rready_o;
    logic        ex_we_i;
    logic [5:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        wb_contention_o;
    logic        rf_we_o;
    logic [5:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [3:0]  x_level_o;

    cv32e40p_x_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .x_rvalid_i(x_rvalid_i), .x_rd_i(x_rd_i), .x_data_i(x_data_i), .x_rready_o(x_rready_o),
        .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .wb_contention_o(wb_contention_o),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .x_level_o(x_level_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   starve = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic        obs_rdy, obs_we, obs_cont;
    logic [5:0]  obs_addr;
    logic [31:0] obs_data;
    logic [3:0]  obs_level;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model, clock.
    task automatic step(input logic r, input logic xv, input logic [4:0] xrd, input logic [31:0] xd,
                        input logic ew, input logic [5:0] ea, input logic [31:0] ed);
        logic        e_rdy, e_we, e_cont, xfer, haz, popped, wrote_x;
        logic [5:0]  e_addr;
        logic [31:0] e_data;
        int          e_level;
        rst = r; x_rvalid_i = xv; x_rd_i = xrd; x_data_i = xd;
        ex_we_i = ew; ex_waddr_i = ea; ex_wdata_i = ed;
        #1;
        obs_rdy = x_rready_o; obs_we = rf_we_o; obs_cont = wb_contention_o;
        obs_addr = rf_waddr_o; obs_data = rf_wdata_o; obs_level = x_level_o;

        e_rdy = 0; e_we = 0; e_cont = 0; e_addr = 0; e_data = 0; popped = 0; wrote_x = 0;
        e_level = r ? 0 : q.size();
        if (!r) begin
            e_rdy = (q.size() < DEPTH);
            xfer  = xv && e_rdy;
            haz   = 0;
            foreach (q[i]) if (ew && q[i].addr == ea) haz = 1;
            if (q.size() > 0 && (haz || starve == STARVE_LIMIT || !ew)) begin
                e_we = 1; e_addr = q[0].addr; e_data = q[0].data; e_cont = ew; popped = 1;
            end else if (ew) begin
                e_we = 1; e_addr = ea; e_data = ed;
            end else if (xfer && xrd != 0) begin
                e_we = 1; e_addr = {1'b0, xrd}; e_data = xd; wrote_x = 1;
            end
            if (q.size() == 0 || popped) starve = 0;
            else if (starve < STARVE_LIMIT) starve++;
            if (popped) void'(q.pop_front());
            if (xfer && xrd != 0 && !wrote_x) q.push_back('{addr: {1'b0, xrd}, data: xd});
        end else begin
            q.delete();
            starve = 0;
        end

        check("x_rready", {31'd0, obs_rdy}, {31'd0, e_rdy});
        check("rf_we", {31'd0, obs_we}, {31'd0, e_we});
        check("rf_waddr", {26'd0, obs_addr}, {26'd0, e_addr});
        check("rf_wdata", obs_data, e_data);
        check("contention", {31'd0, obs_cont}, {31'd0, e_cont});
        check("x_level", {28'd0, obs_level}, 32'(e_level));
        @(posedge clk);
        #2;
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // Bypass into an empty buffer.
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        check("byp_we", {31'd0, obs_we}, 32'd1);
        check("byp_addr", {26'd0, obs_addr}, 32'd5);
        check("byp_data", obs_data, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 0);
        check("byp_level", {28'd0, obs_level}, 32'd0);

        // Fill and backpressure, then in-order drain.
        step(0, 1, 3, 32'hA3, 1, 10, 32'hE0);
        step(0, 1, 4, 32'hA4, 1, 10, 32'hE1);
        step(0, 1, 6, 32'hA6, 1, 10, 32'hE2);
        check("fill_level", {28'd0, obs_level}, 32'd2);
        check("fill_rdy", {31'd0, obs_rdy}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("drain0", {26'd0, obs_addr}, 32'd3);
        step(0, 0, 0, 0, 0, 0, 0);
        check("drain1", {26'd0, obs_addr}, 32'd4);

        // Ordering hazard on a buffered destination.
        step(0, 1, 7, 32'hC7, 1, 20, 32'h20);
        step(0, 0, 0, 0, 1, 7, 32'hEE);
        check("haz_addr", {26'd0, obs_addr}, 32'd7);
        check("haz_data", obs_data, 32'hC7);
        check("haz_cont", {31'd0, obs_cont}, 32'd1);
        step(0, 0, 0, 0, 1, 7, 32'hEE);
        check("haz_ex", obs_data, 32'hEE);
        check("haz_cont2", {31'd0, obs_cont}, 32'd0);

        // Starvation: EX wins STARVE_LIMIT cycles, then the head is forced through.
        step(0, 1, 11, 32'hB11, 1, 9, 32'h99);
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            step(0, 0, 0, 0, 1, 9, 32'h99);
            check("stv_ex", {26'd0, obs_addr}, 32'd9);
        end
        step(0, 0, 0, 0, 1, 9, 32'h99);
        check("stv_head", {26'd0, obs_addr}, 32'd11);
        check("stv_cont", {31'd0, obs_cont}, 32'd1);
        step(0, 0, 0, 0, 1, 9, 32'h99);
        check("stv_after", {26'd0, obs_addr}, 32'd9);

        // x0 results are accepted and dropped.
        step(0, 1, 0, 32'h123, 0, 0, 0);
        check("x0_rdy", {31'd0, obs_rdy}, 32'd1);
        check("x0_we", {31'd0, obs_we}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("x0_level", {28'd0, obs_level}, 32'd0);

        // Reset discards buffered results.
        step(0, 1, 12, 32'hC12, 1, 30, 0);
        step(0, 1, 13, 32'hC13, 1, 30, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_level", {28'd0, obs_level}, 32'd0);
        check("rst_rdy", {31'd0, obs_rdy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            check("rst_nowr", {31'd0, obs_we}, 32'd0);
        end

        // Random traffic with a narrow address range to provoke hazards.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 99) < 2), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                 $urandom, $urandom_range(0, 1) == 1, 6'($urandom_range(0, 8)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cv32e40p_x_wb_arbiter.md
CV32E40P_X_WB_ARBITER -- requirements
Module: cv32e40p_x_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, number of X-result buffer entries; power of two, 2..8.
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive lost cycles before a buffered X result is forced through; 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising clk edge.
REQ-005 x_rvalid_i  input  1  coprocessor result valid.
REQ-006 x_rd_i  input  5  coprocessor destination register.
REQ-007 x_data_i  input  32  coprocessor result data.
REQ-008 x_rready_o  output  1  arbiter accepts the X result this cycle.
REQ-009 ex_we_i  input  1  EX stage requests an ALU-port write this cycle.
REQ-010 ex_waddr_i  input  6  EX write address.
REQ-011 ex_wdata_i  input  32  EX write data.
REQ-012 wb_contention_o  output  1  EX write not granted; EX holds its instruction.
REQ-013 rf_we_o  output  1  register-file ALU-port write enable.
REQ-014 rf_waddr_o  output  6  register-file write address.
REQ-015 rf_wdata_o  output  32  register-file write data.
REQ-016 x_level_o  output  4  number of valid buffer entries.

Function
REQ-017 X handshake: transfer occurs when x_rvalid_i and x_rready_o are both high; x_rready_o is high exactly when the buffer is not full; no push-on-pop while full.
REQ-018 A transferred X result with x_rd_i == 0 is discarded: not buffered, never written.
REQ-019 Buffer is FIFO; push writes the tail entry {1'b0, x_rd_i}, x_data_i; pop removes the head; pointers wrap modulo DEPTH.
REQ-020 Simultaneous push and pop when not full: level unchanged, both pointers advance.
REQ-021 Bypass: buffer empty, ex_we_i low, transferred X result with rd != 0: written the same cycle, not buffered.
REQ-022 Default grant: ex_we_i high -> EX written (rf_* = ex_*), wb_contention_o low; otherwise, if buffer non-empty, head written and popped.
REQ-023 Ordering hazard: ex_we_i high and ex_waddr_i equals the address of any valid buffer entry -> head granted and popped, wb_contention_o high; repeats each cycle until no match.
REQ-024 Starvation: counter increments each cycle the buffer is non-empty and the head is not granted; saturates at STARVE_LIMIT.
REQ-025 Counter == STARVE_LIMIT: head granted and popped, wb_contention_o high if ex_we_i; counter clears on any pop or when the buffer is empty.
REQ-026 Hazard or starvation grant takes priority over the bypass path; the incoming X result is buffered if not full.
REQ-027 wb_contention_o is low whenever ex_we_i is low.
REQ-028 At most one rf write per cycle; rf_we_o low implies rf_waddr_o = 0 and rf_wdata_o = 0.
REQ-029 All rf_* and wb_contention_o outputs are combinational from current state and inputs, with zero latency; buffer write latency is 1 cycle.
REQ-030 x_level_o equals the registered entry count, 0..DEPTH.

Reset
REQ-031 While rst is high: buffer emptied, pointers 0, starvation counter 0, x_level_o = 0.
REQ-032 While rst is high: x_rready_o = 0, rf_we_o = 0, wb_contention_o = 0.
REQ-033 Reset mid-operation discards all buffered results without writing them; the first grant after reset follows REQ-022.

Verification
REQ-034 Bypass: empty buffer, ex_we_i = 0, X rd = 5, data 0xDEADBEEF -> same cycle rf_we_o = 1, rf_waddr_o = 5, rf_wdata_o = 0xDEADBEEF; x_level_o stays 0.
REQ-035 Fill and backpressure: ex_we_i held 1 (addr 10), 2 X results (rd 3 and rd 4) -> x_level_o = 2, x_rready_o = 0; then ex_we_i = 0 -> rd 3 written, then rd 4, in order.
REQ-036 Hazard: buffer holds rd 7; EX writes addr 7 -> first cycle rf_waddr_o = 7 with X data and wb_contention_o = 1; next cycle EX data written to 7 with wb_contention_o = 0.
REQ-037 Starvation, STARVE_LIMIT = 4: one buffered entry, ex_we_i held 1 to unrelated addr 9 -> EX granted 4 cycles; 5th cycle head written and wb_contention_o = 1; 6th cycle EX granted.
REQ-038 x0 drop: X rd = 0 with ex_we_i = 0 -> x_rready_o = 1, rf_we_o = 0, x_level_o = 0.
REQ-039 Reset: 2 entries buffered, rst high for 1 cycle -> x_level_o = 0, rf_we_o = 0, x_rready_o = 0 during reset; no buffered write ever appears afterward.
